// File: rtl/pe_seq_fsm.sv
// PE array sequencer: ifm/weight read strobes plus delayed partial-sum flags.
// Optional stall performance counter when PE_SEQ_PERF_EN is defined.
module pe_seq_fsm #(
    parameter int TILE_LEN     = 16,
    parameter int WGT_LEN      = 4,
    parameter int OUT_LAT      = 4,
    parameter int CFG_W        = 2,
    parameter int CH_UNIT      = 8,
    parameter int TILES_PER_CO = 52,
    parameter int PASS_W       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_conv,
    input  logic             start_again,
    input  logic [CFG_W-1:0] cfg_ci,
    input  logic [CFG_W-1:0] cfg_co,
    input  logic             stall,
    output logic             ifm_read,
    output logic             wgt_read,
    output logic             p_valid_out,
    output logic             last_ch_out,
    output logic             tile_done,
    output logic             end_conv,
    output logic             busy
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int CH_MAX   = (2 ** CFG_W) * CH_UNIT;
    localparam int CH_W     = $clog2(CH_MAX + 1);
    localparam int STEP_MAX = (TILE_LEN > WGT_LEN) ? TILE_LEN : WGT_LEN;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    localparam logic [STEP_W-1:0] LOAD_END   = STEP_W'(WGT_LEN - 1);
    localparam logic [STEP_W-1:0] STREAM_END = STEP_W'(TILE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     ci_q, ci_d;
    logic [CH_W-1:0]     co_q, co_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [OUT_LAT-1:0]  pv_pipe_q;
    logic [OUT_LAT-1:0]  lc_pipe_q;

    logic                pv_raw;
    logic                lc_raw;
    logic                ch_last;
    logic                pass_last;
    logic [CH_W:0]       ch_inc;
    logic [PASS_W:0]     pass_inc;
    logic [PASS_W-1:0]   pass_total;
    logic [CH_W-1:0]     ci_cfg;
    logic [CH_W-1:0]     co_cfg;

    // ">=" rather than "==" so an unconfigured ci/co of 0 behaves like 1
    assign ch_inc     = {1'b0, ch_q} + (CH_W + 1)'(1);
    assign ch_last    = ch_inc >= {1'b0, ci_q};
    assign pass_total = PASS_W'(co_q) * PASS_W'(TILES_PER_CO);
    assign pass_inc   = {1'b0, pass_q} + (PASS_W + 1)'(1);
    assign pass_last  = pass_inc >= {1'b0, pass_total};

    assign ci_cfg = CH_W'((int'(cfg_ci) + 1) * CH_UNIT);
    assign co_cfg = CH_W'((int'(cfg_co) + 1) * CH_UNIT);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ch_d      = ch_q;
        ci_d      = ci_q;
        co_d      = co_q;
        pass_d    = pass_q;
        ifm_read  = 1'b0;
        wgt_read  = 1'b0;
        pv_raw    = 1'b0;
        lc_raw    = 1'b0;
        tile_done = 1'b0;
        end_conv  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_conv) begin
                    ci_d   = ci_cfg;
                    co_d   = co_cfg;
                    pass_d = '0;
                end else if (start_again) begin
                    step_d  = '0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (!stall) begin
                    ifm_read = 1'b1;
                    wgt_read = 1'b1;
                    if (step_q == LOAD_END) begin
                        step_d  = '0;
                        state_d = S_STREAM;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end

            S_STREAM: begin
                if (!stall) begin
                    ifm_read = 1'b1;
                    pv_raw   = 1'b1;
                    lc_raw   = ch_last;
                    if (step_q == STREAM_END) begin
                        step_d = '0;
                        if (!ch_last) begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = S_LOAD;
                        end else begin
                            ch_d      = '0;
                            tile_done = 1'b1;
                            if (pass_last) begin
                                state_d = S_DONE;
                            end else begin
                                pass_d  = pass_q + PASS_W'(1);
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end

            S_DONE: begin
                end_conv = 1'b1;
                pass_d   = '0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            ch_q    <= '0;
            ci_q    <= '0;
            co_q    <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ch_q    <= ch_d;
            ci_q    <= ci_d;
            co_q    <= co_d;
            pass_q  <= pass_d;
        end
    end

    // Delay pipe shifts every cycle, so stalls show up as bubbles downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_pipe_q <= '0;
            lc_pipe_q <= '0;
        end else begin
            pv_pipe_q[0] <= pv_raw;
            lc_pipe_q[0] <= lc_raw;
            for (int i = 1; i < OUT_LAT; i++) begin
                pv_pipe_q[i] <= pv_pipe_q[i-1];
                lc_pipe_q[i] <= lc_pipe_q[i-1];
            end
        end
    end

    assign p_valid_out = pv_pipe_q[OUT_LAT-1];
    assign last_ch_out = lc_pipe_q[OUT_LAT-1];
    assign busy        = (state_q != S_IDLE);

`ifdef PE_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        perf_hit;

    assign perf_hit = stall && ((state_q == S_LOAD) || (state_q == S_STREAM));

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start_conv) begin
            perf_d = '0;
        end else if (perf_hit && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pe_seq_fsm.sv
// Self-checking bench for pe_seq_fsm: directed passes plus random traffic
// against a slot-level reference model of one pass.
module tb_pe_seq_fsm;

    localparam int TL   = 16;
    localparam int WL   = 4;
    localparam int OL   = 4;
    localparam int CW   = 2;
    localparam int CU   = 8;
    localparam int TPC  = 2;
    localparam int PW   = 12;
    localparam int STEP = TL + WL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_conv;
    logic          start_again;
    logic          stall;
    logic [CW-1:0] cfg_ci;
    logic [CW-1:0] cfg_co;
    logic          ifm_read;
    logic          wgt_read;
    logic          p_valid_out;
    logic          last_ch_out;
    logic          tile_done;
    logic          end_conv;
    logic          busy;
`ifdef PE_SEQ_PERF_EN
    logic [31:0]   perf_stall_cnt;
`endif

    pe_seq_fsm #(
        .TILE_LEN    (TL),
        .WGT_LEN     (WL),
        .OUT_LAT     (OL),
        .CFG_W       (CW),
        .CH_UNIT     (CU),
        .TILES_PER_CO(TPC),
        .PASS_W      (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_conv    (start_conv),
        .start_again   (start_again),
        .cfg_ci        (cfg_ci),
        .cfg_co        (cfg_co),
        .stall         (stall),
        .ifm_read      (ifm_read),
        .wgt_read      (wgt_read),
        .p_valid_out   (p_valid_out),
        .last_ch_out   (last_ch_out),
        .tile_done     (tile_done),
        .end_conv      (end_conv),
`ifdef PE_SEQ_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    // reference model: a pass is a list of ci*STEP work slots
    bit     m_busy;
    bit     m_done;
    int     m_slot;
    int     m_ci;
    int     m_co;
    int     m_pass;
    bit     pvh[OL];
    bit     lch[OL];
    longint m_perf;

    int n_ifm, n_wgt, n_pv, n_lc, n_td, n_ec, n_busy;
    int first_pv, td_at, ec_at;
    int cyc_n = 0;
    int t;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_slot = 0;
        m_ci   = 0;
        m_co   = 0;
        m_pass = 0;
        m_perf = 0;
        for (int i = 0; i < OL; i++) begin
            pvh[i] = 1'b0;
            lch[i] = 1'b0;
        end
    endtask

    task automatic clr();
        n_ifm    = 0;
        n_wgt    = 0;
        n_pv     = 0;
        n_lc     = 0;
        n_td     = 0;
        n_ec     = 0;
        n_busy   = 0;
        first_pv = -1;
        td_at    = -1;
        ec_at    = -1;
    endtask

    task automatic cyc(input bit sa, input bit sc, input bit st, input bit rs);
        bit e_ifm, e_wgt, e_pv, e_lc, e_td, e_ec, e_busy;
        int stp, off;
        start_again = sa;
        start_conv  = sc;
        stall       = st;
        rst         = rs;
        @(negedge clk);
        e_ifm  = 0;
        e_wgt  = 0;
        e_pv   = 0;
        e_lc   = 0;
        e_td   = 0;
        e_ec   = 0;
        e_busy = 0;
        if (m_done) begin
            e_ec   = 1;
            e_busy = 1;
        end else if (m_busy) begin
            e_busy = 1;
            if (!st) begin
                stp   = m_slot / STEP;
                off   = m_slot % STEP;
                e_ifm = 1;
                e_wgt = (off < WL);
                e_pv  = (off >= WL);
                e_lc  = e_pv && (stp == m_ci - 1);
                e_td  = (m_slot == m_ci * STEP - 1);
            end
        end
        chk("outs",
            64'({ifm_read, wgt_read, p_valid_out, last_ch_out,
                 tile_done, end_conv, busy}),
            64'({e_ifm, e_wgt, pvh[OL-1], lch[OL-1], e_td, e_ec, e_busy}));
`ifdef PE_SEQ_PERF_EN
        chk("perf", 64'(perf_stall_cnt), 64'(m_perf));
`endif
        n_ifm  += int'(ifm_read);
        n_wgt  += int'(wgt_read);
        n_pv   += int'(p_valid_out);
        n_lc   += int'(last_ch_out);
        n_td   += int'(tile_done);
        n_ec   += int'(end_conv);
        n_busy += int'(busy);
        if (p_valid_out && first_pv < 0) first_pv = cyc_n;
        if (tile_done) td_at = cyc_n;
        if (end_conv) ec_at = cyc_n;

        if (rs) begin
            model_reset();
        end else begin
            for (int i = OL - 1; i > 0; i--) begin
                pvh[i] = pvh[i-1];
                lch[i] = lch[i-1];
            end
            pvh[0] = e_pv;
            lch[0] = e_lc;
            if (!m_busy && !m_done && sc) m_perf = 0;
            else if (m_busy && st && m_perf != 64'hffff_ffff) m_perf++;
            if (m_done) begin
                m_done = 0;
                m_pass = 0;
            end else if (m_busy) begin
                if (!st) begin
                    m_slot++;
                    if (m_slot == m_ci * STEP) begin
                        m_busy = 0;
                        if (m_pass == m_co * TPC - 1) m_done = 1;
                        else m_pass++;
                    end
                end
            end else if (sc) begin
                m_ci   = (int'(cfg_ci) + 1) * CU;
                m_co   = (int'(cfg_co) + 1) * CU;
                m_pass = 0;
            end else if (sa) begin
                m_busy = 1;
                m_slot = 0;
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start_conv  = 1'b0;
        start_again = 1'b0;
        stall       = 1'b0;
        cfg_ci      = '0;
        cfg_co      = '0;
        @(posedge clk);
        #1;
        model_reset();
        clr();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("reset_busy", 64'(n_busy), 64'(0));

        // single pass, ci = 8
        cyc(0, 1, 0, 0);
        clr();
        t = cyc_n;
        cyc(1, 0, 0, 0);
        idle(175);
        chk("p1_ifm", 64'(n_ifm), 64'(160));
        chk("p1_wgt", 64'(n_wgt), 64'(32));
        chk("p1_pv", 64'(n_pv), 64'(128));
        chk("p1_lc", 64'(n_lc), 64'(16));
        chk("p1_td", 64'(n_td), 64'(1));
        chk("p1_td_at", 64'(td_at), 64'(t + 160));
        chk("p1_first_pv", 64'(first_pv), 64'(t + 9));
        chk("p1_busy", 64'(n_busy), 64'(160));

        // full layer: co = 8, two tiles per group -> 16 passes
        cyc(0, 1, 0, 0);
        clr();
        for (int p = 0; p < 16; p++) begin
            cyc(1, 0, 0, 0);
            idle(165);
        end
        chk("layer_td", 64'(n_td), 64'(16));
        chk("layer_ec", 64'(n_ec), 64'(1));
        chk("layer_ec_at", 64'(ec_at), 64'(td_at + 1));
        clr();
        cyc(1, 0, 0, 0);
        idle(165);
        chk("p17_ifm", 64'(n_ifm), 64'(160));
        chk("p17_ec", 64'(n_ec), 64'(0));

        // three stall cycles in step 2 STREAM
        clr();
        t = cyc_n;
        cyc(1, 0, 0, 0);
        idle(49);
        repeat (3) cyc(0, 0, 1, 0);
        idle(130);
        chk("stall_busy", 64'(n_busy), 64'(163));
        chk("stall_pv", 64'(n_pv), 64'(128));
        chk("stall_ifm", 64'(n_ifm), 64'(160));
        chk("stall_td_at", 64'(td_at), 64'(t + 163));

        // start_again while busy, cfg changes while busy
        clr();
        cyc(1, 0, 0, 0);
        idle(10);
        cyc(1, 0, 0, 0);
        cfg_ci = 2'd3;
        idle(20);
        cyc(1, 0, 0, 0);
        idle(140);
        chk("busy_sa_busy", 64'(n_busy), 64'(160));
        chk("busy_sa_ifm", 64'(n_ifm), 64'(160));
        cfg_ci = 2'd1;
        clr();
        cyc(1, 1, 0, 0);
        idle(10);
        chk("sc_sa_busy", 64'(n_busy), 64'(0));
        clr();
        cyc(1, 0, 0, 0);
        idle(330);
        chk("ci16_ifm", 64'(n_ifm), 64'(320));
        chk("ci16_lc", 64'(n_lc), 64'(16));
        chk("ci16_busy", 64'(n_busy), 64'(320));
        cfg_ci = 2'd0;

        // reset mid-pass
        cyc(0, 1, 0, 0);
        clr();
        cyc(1, 0, 0, 0);
        idle(49);
        cyc(0, 0, 0, 1);
        chk("rst_outs",
            64'({ifm_read, wgt_read, p_valid_out, last_ch_out,
                 tile_done, end_conv, busy}), 64'(0));
        idle(20);
        chk("rst_ec", 64'(n_ec), 64'(0));
        cyc(0, 1, 0, 0);
        clr();
        cyc(1, 0, 0, 0);
        idle(170);
        chk("post_rst_ifm", 64'(n_ifm), 64'(160));
        chk("post_rst_pv", 64'(n_pv), 64'(128));

`ifdef PE_SEQ_PERF_EN
        cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        idle(1);
        repeat (2) cyc(0, 0, 1, 0);
        idle(10);
        repeat (3) cyc(0, 0, 1, 0);
        idle(160);
        chk("perf_5", 64'(perf_stall_cnt), 64'(5));
        cyc(0, 1, 0, 0);
        chk("perf_clr", 64'(perf_stall_cnt), 64'(0));
`endif

        // random traffic
        cyc(0, 1, 0, 0);
        repeat (2500) begin
            bit sa, sc, st;
            sa = ($urandom_range(0, 19) == 0);
            sc = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) cfg_ci = CW'($urandom_range(0, 1));
            cyc(sa, sc, st, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_seq_fsm.md
Name: pe_seq_fsm

Overview:
Parametrised sequencing FSM for the PE array. It generates ifm/weight read strobes and the delayed partial-sum valid and last-channel flags for one convolution layer. Each pass walks all input-channel steps of one tile. A layer is complete after co*TILES_PER_CO passes. It adds generic tile and load lengths, a stall input, a busy flag and an automatic end-of-layer pulse.

Parameters:
TILE_LEN, 16, stream cycles per channel step (ifm only)
WGT_LEN, 4, load cycles per channel step (ifm+wgt)
OUT_LAT, 4, register stages on p_valid_out/last_ch_out (>=1)
CFG_W, 2, width of cfg_ci/cfg_co
CH_UNIT, 8, channels per cfg increment; ci=(cfg_ci+1)*CH_UNIT, co likewise
TILES_PER_CO, 52, passes per output-channel group
PASS_W, 12, pass counter width; must hold (2^CFG_W)*CH_UNIT*TILES_PER_CO

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_conv  in  1  latch cfg, clear pass counter (IDLE only)
start_again  in  1  start one pass (IDLE only)
cfg_ci  in  CFG_W  input-channel config
cfg_co  in  CFG_W  output-channel config
stall  in  1  freeze sequencing this cycle
ifm_read  out  1  ifm buffer read strobe
wgt_read  out  1  weight buffer read strobe
p_valid_out  out  1  partial-sum valid, delayed OUT_LAT
last_ch_out  out  1  valid sum belongs to last input channel, delayed OUT_LAT
tile_done  out  1  one-cycle pulse on the final cycle of each pass
end_conv  out  1  one-cycle pulse when the layer completes
busy  out  1  state != IDLE

Behaviour:
- One clock domain; reset is synchronous and active-high. The reset port is named rst and the clock port clk.
- Reset state: IDLE. All counters, ci/co registers and delay pipes are 0. Every output is 0.
- States: IDLE, LOAD, STREAM, DONE.
- Counters:
  - step_cnt counts cycles within a phase.
  - ch_cnt runs 0..ci-1.
  - pass_cnt runs 0..co*TILES_PER_CO-1.
- start_conv in IDLE latches ci and co from cfg and clears pass_cnt. It is ignored outside IDLE.
- start_conv has priority over start_again in the same cycle; that start_again is dropped.
- IDLE->LOAD: on start_again when start_conv is low.
- LOAD lasts WGT_LEN unstalled cycles, then -> STREAM.
- STREAM lasts TILE_LEN unstalled cycles. Then:
  - if ch_cnt<ci-1: ch_cnt++ and -> LOAD;
  - else ch_cnt=0 and tile_done=1 on that last STREAM cycle, then:
    - if pass_cnt==co*TILES_PER_CO-1: -> DONE;
    - else: pass_cnt++ and -> IDLE.
- DONE lasts 1 cycle: end_conv=1, pass_cnt cleared, -> IDLE.
- Strobes are a combinational decode of the current state, ANDed with !stall:
  - ifm_read=1 in LOAD and STREAM;
  - wgt_read=1 in LOAD;
  - raw p_valid=1 in STREAM;
  - raw last_ch=1 in STREAM when ch_cnt==ci-1.
- p_valid_out and last_ch_out are the raw signals through an OUT_LAT-deep shift register. The shift register always shifts, so stall inserts bubbles.
- Stall in LOAD/STREAM freezes the state and all counters; strobes are 0. Stall in IDLE/DONE has no effect.
- Timing: start_again at cycle t gives ifm_read on t+1..t+WGT_LEN+TILE_LEN for step 0. The first p_valid_out is at t+WGT_LEN+1+OUT_LAT.
- Pass length unstalled: ci*(WGT_LEN+TILE_LEN) cycles.
- start_again while busy is ignored.
- rst mid-pass returns to the reset state on the next edge and flushes the delay pipe; no end_conv is issued.
- pass_cnt compare uses the full product co*TILES_PER_CO at PASS_W bits with no truncation.

Optional Feature:
PE_SEQ_PERF_EN:
- With the macro: adds output perf_stall_cnt (32 bits). It counts cycles where stall=1 in LOAD/STREAM, saturates at all-ones, is cleared by rst and by start_conv, and holds its value otherwise.
- Without the macro: the port and counter do not exist, and the rest of the behaviour is unchanged.

Test Plan:
- Single pass, defaults, cfg_ci=0 (ci=8), start_again at t -> ifm_read high 160 cycles, wgt_read 32, p_valid_out 128, last_ch_out 16 (final step only). First p_valid_out at t+9; tile_done once at t+160; busy 160 cycles.
- Full layer, TILES_PER_CO=2, cfg_co=0 (co=8), cfg_ci=0 -> 16 passes, each started by start_again. end_conv pulses once, one cycle after the 16th pass's tile_done. pass_cnt is then 0, and a 17th pass restarts cleanly.
- Stall 3 cycles mid-STREAM of step 2 -> pass is 163 cycles. Strobes are 0 during the stall, p_valid_out shows a 3-cycle gap, and total p_valid_out is still 128.
- start_again during busy, and start_conv+start_again in the same IDLE cycle -> both start_agains are ignored. Cfg latches only in IDLE (cfg changes while busy don't alter ci).
- rst asserted at cycle 50 of a pass -> next cycle all outputs are 0 and the state is IDLE; no end_conv; the following start_again gives a normal full pass.
- PE_SEQ_PERF_EN defined, 5 stall cycles in LOAD/STREAM plus 2 in IDLE -> perf_stall_cnt=5; start_conv -> 0.
